// File: rtl/point_generator.sv
// Pseudo-random (x, y) point source for the Monte Carlo pi datapath.
// A 32-bit Galois LFSR feeds a valid/ready handshake that emits a programmed number of points.
module point_generator #(
    parameter logic [31:0] SEED        = 32'hACE1_2468,
    parameter logic [31:0] TAPS        = 32'h8020_0003,
    parameter int unsigned COUNT_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   seedLoad,
    input  logic [31:0]            seedIn,
    input  logic [COUNT_WIDTH-1:0] numPoints,
    output logic [31:0]            x,
    output logic [31:0]            y,
    output logic                   valid,
    input  logic                   ready,
    output logic                   busy,
    output logic                   done,
    output logic [COUNT_WIDTH-1:0] pointsSent
);

    typedef enum logic [1:0] {
        IDLE,
        GEN_X,
        GEN_Y,
        PRESENT
    } state_t;

    state_t                 state_q, state_d;
    logic [31:0]            lfsr_q, lfsr_d;
    logic [31:0]            x_q, x_d;
    logic [31:0]            y_q, y_d;
    logic                   valid_q, valid_d;
    logic                   done_q, done_d;
    logic [COUNT_WIDTH-1:0] sent_q, sent_d;
    logic [COUNT_WIDTH-1:0] target_q, target_d;
    logic [31:0]            lfsr_next;
    logic [COUNT_WIDTH-1:0] sent_inc;

    function automatic logic [31:0] lfsr_step(input logic [31:0] v);
        return v[0] ? ((v >> 1) ^ TAPS) : (v >> 1);
    endfunction

    always_comb begin
        state_d   = state_q;
        lfsr_d    = lfsr_q;
        x_d       = x_q;
        y_d       = y_q;
        valid_d   = valid_q;
        done_d    = done_q;
        sent_d    = sent_q;
        target_d  = target_q;
        lfsr_next = lfsr_step(lfsr_q);
        sent_inc  = sent_q + {{(COUNT_WIDTH-1){1'b0}}, 1'b1};

        case (state_q)
            IDLE: begin
                valid_d = 1'b0;
                // seedLoad wins over a simultaneous start
                if (seedLoad) begin
                    lfsr_d = (seedIn == '0) ? SEED : seedIn;
                end else if (start) begin
                    sent_d = '0;
                    if (numPoints != '0) begin
                        target_d = numPoints;
                        done_d   = 1'b0;
                        state_d  = GEN_X;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            GEN_X: begin
                lfsr_d  = lfsr_next;
                x_d     = lfsr_next;
                state_d = GEN_Y;
            end
            GEN_Y: begin
                lfsr_d  = lfsr_next;
                y_d     = lfsr_next;
                valid_d = 1'b1;
                state_d = PRESENT;
            end
            PRESENT: begin
                if (ready) begin
                    sent_d  = sent_inc;
                    valid_d = 1'b0;
                    if (sent_inc == target_q) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        state_d = GEN_X;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            lfsr_q   <= SEED;
            x_q      <= '0;
            y_q      <= '0;
            valid_q  <= 1'b0;
            done_q   <= 1'b0;
            sent_q   <= '0;
            target_q <= '0;
        end else begin
            state_q  <= state_d;
            lfsr_q   <= lfsr_d;
            x_q      <= x_d;
            y_q      <= y_d;
            valid_q  <= valid_d;
            done_q   <= done_d;
            sent_q   <= sent_d;
            target_q <= target_d;
        end
    end

    assign x          = x_q;
    assign y          = y_q;
    assign valid      = valid_q;
    assign busy       = (state_q != IDLE);
    assign done       = done_q;
    assign pointsSent = sent_q;

endmodule

// File: tb/tb_point_generator.sv
// Directed self-checking bench for point_generator with hand-computed LFSR points.
module tb_point_generator;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        seedLoad;
    logic [31:0] seedIn;
    logic [31:0] numPoints;
    logic [31:0] x;
    logic [31:0] y;
    logic        valid;
    logic        ready;
    logic        busy;
    logic        done;
    logic [31:0] pointsSent;

    int vectors     = 0;
    int miscompares = 0;

    // Hand-computed points: seed 1 and default seed 0xACE1_2468
    localparam logic [31:0] S1_X0  = 32'h8020_0003;
    localparam logic [31:0] S1_Y0  = 32'hC030_0002;
    localparam logic [31:0] S1_X1  = 32'h6018_0001;
    localparam logic [31:0] S1_Y1  = 32'hB02C_0003;
    localparam logic [31:0] DEF_X0 = 32'h5670_9234;
    localparam logic [31:0] DEF_Y0 = 32'h2B38_491A;
    localparam logic [31:0] DEF_X1 = 32'h159C_248D;
    localparam logic [31:0] DEF_Y1 = 32'h8AEE_1245;

    point_generator #(
        .SEED        (32'hACE1_2468),
        .TAPS        (32'h8020_0003),
        .COUNT_WIDTH (32)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .seedLoad   (seedLoad),
        .seedIn     (seedIn),
        .numPoints  (numPoints),
        .x          (x),
        .y          (y),
        .valid      (valid),
        .ready      (ready),
        .busy       (busy),
        .done       (done),
        .pointsSent (pointsSent)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        start     = 1'b0;
        seedLoad  = 1'b0;
        seedIn    = '0;
        numPoints = '0;
        ready     = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic wait_valid(input string name);
        for (int i = 0; i < 20; i++) begin
            if (valid) break;
            tick();
        end
        vectors++;
        if (valid !== 1'b1) begin
            miscompares++;
            $display("FAIL %s: valid timeout, got %b want 1", name, valid);
        end
    endtask

    task automatic pulse_start(input logic [31:0] n);
        start     = 1'b1;
        numPoints = n;
        tick();
        start     = 1'b0;
    endtask

    task automatic load_seed(input logic [31:0] s);
        seedLoad = 1'b1;
        seedIn   = s;
        tick();
        seedLoad = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        vectors += 6;
        if (valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b want 0", valid); end
        if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", busy); end
        if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b want 0", done); end
        if (pointsSent !== 32'd0) begin miscompares++; $display("FAIL reset_sent: got %0d want 0", pointsSent); end
        if (x !== 32'd0) begin miscompares++; $display("FAIL reset_x: got %h want 0", x); end
        if (y !== 32'd0) begin miscompares++; $display("FAIL reset_y: got %h want 0", y); end
    endtask

    task automatic test_basic();
        load_seed(32'd1);
        ready = 1'b1;
        pulse_start(32'd2);
        vectors += 3;
        if (valid !== 1'b0) begin miscompares++; $display("FAIL basic_lat1: valid got %b want 0", valid); end
        if (busy !== 1'b1) begin miscompares++; $display("FAIL basic_busy: got %b want 1", busy); end
        tick();
        if (valid !== 1'b0) begin miscompares++; $display("FAIL basic_lat2: valid got %b want 0", valid); end
        tick();
        vectors += 3;
        if (valid !== 1'b1) begin miscompares++; $display("FAIL basic_lat3: valid got %b want 1", valid); end
        if (x !== S1_X0) begin miscompares++; $display("FAIL basic_x0: got %h want %h", x, S1_X0); end
        if (y !== S1_Y0) begin miscompares++; $display("FAIL basic_y0: got %h want %h", y, S1_Y0); end
        tick();
        tick();
        vectors++;
        if (valid !== 1'b0) begin miscompares++; $display("FAIL basic_gap: valid got %b want 0", valid); end
        tick();
        vectors += 3;
        if (valid !== 1'b1) begin miscompares++; $display("FAIL basic_space: valid got %b want 1", valid); end
        if (x !== S1_X1) begin miscompares++; $display("FAIL basic_x1: got %h want %h", x, S1_X1); end
        if (y !== S1_Y1) begin miscompares++; $display("FAIL basic_y1: got %h want %h", y, S1_Y1); end
        tick();
        ready = 1'b0;
        vectors += 4;
        if (done !== 1'b1) begin miscompares++; $display("FAIL basic_done: got %b want 1", done); end
        if (busy !== 1'b0) begin miscompares++; $display("FAIL basic_idle: busy got %b want 0", busy); end
        if (valid !== 1'b0) begin miscompares++; $display("FAIL basic_vdrop: valid got %b want 0", valid); end
        if (pointsSent !== 32'd2) begin miscompares++; $display("FAIL basic_sent: got %0d want 2", pointsSent); end
    endtask

    task automatic test_stall();
        load_seed(32'd1);
        ready = 1'b0;
        pulse_start(32'd1);
        wait_valid("stall_wait");
        for (int i = 0; i < 10; i++) begin
            vectors += 3;
            if (valid !== 1'b1) begin miscompares++; $display("FAIL stall_valid[%0d]: got %b want 1", i, valid); end
            if (x !== S1_X0) begin miscompares++; $display("FAIL stall_x[%0d]: got %h want %h", i, x, S1_X0); end
            if (y !== S1_Y0) begin miscompares++; $display("FAIL stall_y[%0d]: got %h want %h", i, y, S1_Y0); end
            tick();
        end
        ready = 1'b1;
        tick();
        ready = 1'b0;
        vectors += 4;
        if (pointsSent !== 32'd1) begin miscompares++; $display("FAIL stall_sent: got %0d want 1", pointsSent); end
        if (done !== 1'b1) begin miscompares++; $display("FAIL stall_done: got %b want 1", done); end
        if (valid !== 1'b0) begin miscompares++; $display("FAIL stall_vdrop: got %b want 0", valid); end
        if (busy !== 1'b0) begin miscompares++; $display("FAIL stall_busy: got %b want 0", busy); end
    endtask

    task automatic test_zero_seed();
        load_seed(32'd0);
        ready = 1'b1;
        pulse_start(32'd1);
        wait_valid("zseed_wait");
        vectors += 2;
        if (x !== DEF_X0) begin miscompares++; $display("FAIL zseed_x: got %h want %h", x, DEF_X0); end
        if (y !== DEF_Y0) begin miscompares++; $display("FAIL zseed_y: got %h want %h", y, DEF_Y0); end
        tick();
        // seedLoad and start together: only the seed takes effect
        seedLoad  = 1'b1;
        seedIn    = 32'd1;
        start     = 1'b1;
        numPoints = 32'd4;
        tick();
        seedLoad  = 1'b0;
        start     = 1'b0;
        vectors += 3;
        if (busy !== 1'b0) begin miscompares++; $display("FAIL both_busy: got %b want 0", busy); end
        if (done !== 1'b1) begin miscompares++; $display("FAIL both_done: got %b want 1", done); end
        if (pointsSent !== 32'd1) begin miscompares++; $display("FAIL both_sent: got %0d want 1", pointsSent); end
        pulse_start(32'd1);
        wait_valid("both_wait");
        vectors++;
        if (x !== S1_X0) begin miscompares++; $display("FAIL both_seed_x: got %h want %h", x, S1_X0); end
        tick();
        ready = 1'b0;
    endtask

    task automatic test_zero_count();
        int hs;
        do_reset();
        pulse_start(32'd0);
        vectors += 3;
        if (done !== 1'b1) begin miscompares++; $display("FAIL zcnt_done: got %b want 1", done); end
        if (busy !== 1'b0) begin miscompares++; $display("FAIL zcnt_busy: got %b want 0", busy); end
        if (pointsSent !== 32'd0) begin miscompares++; $display("FAIL zcnt_sent: got %0d want 0", pointsSent); end
        hs = 0;
        for (int i = 0; i < 6; i++) begin
            if (valid) hs++;
            tick();
        end
        vectors++;
        if (hs != 0) begin miscompares++; $display("FAIL zcnt_novalid: valid cycles %0d want 0", hs); end
        ready = 1'b1;
        pulse_start(32'd3);
        vectors++;
        if (done !== 1'b0) begin miscompares++; $display("FAIL cnt3_clear: done got %b want 0", done); end
        hs = 0;
        for (int i = 0; i < 15; i++) begin
            if (valid && ready) hs++;
            tick();
        end
        ready = 1'b0;
        vectors += 3;
        if (hs != 3) begin miscompares++; $display("FAIL cnt3_hs: got %0d want 3", hs); end
        if (done !== 1'b1) begin miscompares++; $display("FAIL cnt3_done: got %b want 1", done); end
        if (pointsSent !== 32'd3) begin miscompares++; $display("FAIL cnt3_sent: got %0d want 3", pointsSent); end
    endtask

    task automatic test_midrun();
        do_reset();
        ready = 1'b0;
        pulse_start(32'd2);
        wait_valid("mid_wait");
        start     = 1'b1;
        numPoints = 32'd5;
        seedLoad  = 1'b1;
        seedIn    = 32'd1;
        tick();
        start     = 1'b0;
        seedLoad  = 1'b0;
        vectors += 3;
        if (busy !== 1'b1) begin miscompares++; $display("FAIL mid_busy: got %b want 1", busy); end
        if (valid !== 1'b1) begin miscompares++; $display("FAIL mid_valid: got %b want 1", valid); end
        if (x !== DEF_X0) begin miscompares++; $display("FAIL mid_x0: got %h want %h", x, DEF_X0); end
        ready = 1'b1;
        tick();
        ready = 1'b0;
        vectors++;
        if (pointsSent !== 32'd1) begin miscompares++; $display("FAIL mid_sent1: got %0d want 1", pointsSent); end
        wait_valid("mid_wait2");
        vectors += 2;
        if (x !== DEF_X1) begin miscompares++; $display("FAIL mid_x1: got %h want %h", x, DEF_X1); end
        if (y !== DEF_Y1) begin miscompares++; $display("FAIL mid_y1: got %h want %h", y, DEF_Y1); end
        ready = 1'b1;
        tick();
        ready = 1'b0;
        vectors += 3;
        if (done !== 1'b1) begin miscompares++; $display("FAIL mid_done: got %b want 1", done); end
        if (busy !== 1'b0) begin miscompares++; $display("FAIL mid_target: busy got %b want 0", busy); end
        if (pointsSent !== 32'd2) begin miscompares++; $display("FAIL mid_sent2: got %0d want 2", pointsSent); end
    endtask

    task automatic test_reset_present();
        do_reset();
        ready = 1'b0;
        pulse_start(32'd3);
        wait_valid("rst_wait");
        #3 reset = 1'b1;
        #1;
        vectors += 2;
        if (valid !== 1'b0) begin miscompares++; $display("FAIL rst_async_valid: got %b want 0", valid); end
        if (busy !== 1'b0) begin miscompares++; $display("FAIL rst_async_busy: got %b want 0", busy); end
        #6 reset = 1'b0;
        tick();
        vectors += 5;
        if (x !== 32'd0) begin miscompares++; $display("FAIL rst_x: got %h want 0", x); end
        if (y !== 32'd0) begin miscompares++; $display("FAIL rst_y: got %h want 0", y); end
        if (valid !== 1'b0) begin miscompares++; $display("FAIL rst_valid: got %b want 0", valid); end
        if (done !== 1'b0) begin miscompares++; $display("FAIL rst_done: got %b want 0", done); end
        if (pointsSent !== 32'd0) begin miscompares++; $display("FAIL rst_sent: got %0d want 0", pointsSent); end
        ready = 1'b1;
        pulse_start(32'd1);
        wait_valid("rst_seed_wait");
        vectors += 2;
        if (x !== DEF_X0) begin miscompares++; $display("FAIL rst_seed_x: got %h want %h", x, DEF_X0); end
        if (y !== DEF_Y0) begin miscompares++; $display("FAIL rst_seed_y: got %h want %h", y, DEF_Y0); end
        tick();
        ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_zero_seed();
        test_zero_count();
        test_midrun();
        test_reset_present();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
